// File: rtl/fetch_pkg.sv
// Shared types for the instruction-fetch stage.
// Optional perf counters are enabled with FETCH_PERF_CNT_EN.
package fetch_pkg;

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        HELD,
        DRAIN
    } fetch_state_e;

    localparam logic [31:0] NOP_INSTR = 32'h0;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
        logic        valid;
    } ifid_t;

    localparam ifid_t IFID_BUBBLE = '{
        pc:    32'h0,
        instr: NOP_INSTR,
        valid: 1'b0
    };

endpackage

// File: rtl/fetch_if.sv
// Instruction-memory request/acknowledge bundle.
// The fetch stage is the master, instruction memory the slave.
interface fetch_if;

    logic        imem_req_o;
    logic [31:0] imem_addr_o;
    logic        imem_ack_i;
    logic [31:0] imem_data_i;

    modport master (
        output imem_req_o,
        output imem_addr_o,
        input  imem_ack_i,
        input  imem_data_i
    );

    modport slave (
        input  imem_req_o,
        input  imem_addr_o,
        output imem_ack_i,
        output imem_data_i
    );

endinterface

// File: rtl/fetch_hold_buf.sv
// One-entry parking register for a fetched word returned
// while IF/ID is stalled.
module fetch_hold_buf
    import fetch_pkg::*;
(
    input  logic  clk_i,
    input  logic  rst_n_i,
    input  logic  i_load,
    input  logic  i_clr,
    input  ifid_t i_data,
    output ifid_t o_data,
    output logic  o_full
);

    ifid_t r_data;
    logic  r_full;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_data <= IFID_BUBBLE;
            r_full <= 1'b0;
        end else if (i_clr) begin
            r_data <= IFID_BUBBLE;
            r_full <= 1'b0;
        end else if (i_load) begin
            r_data <= i_data;
            r_full <= 1'b1;
        end
    end

    assign o_data = r_data;
    assign o_full = r_full;

endmodule

// File: rtl/fetch_stage.sv
// IF stage: PC register, imem handshake and IF/ID register.
// Define FETCH_PERF_CNT_EN to add stall/bubble/flush counters.
module fetch_stage
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk_i,
    input  logic        rst_n_i,
    input  logic        PC_stall_i,
    input  logic        IFID_stall_i,
    input  logic        flush_i,
    input  logic [31:0] target_i,
    fetch_if.master     imem,
    output logic [31:0] IFID_pc_o,
    output logic [31:0] IFID_instr_o,
    output logic        IFID_valid_o
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [31:0] perf_stall_cnt_o,
    output logic [31:0] perf_bubble_cnt_o,
    output logic [31:0] perf_flush_cnt_o
`endif
);

    fetch_state_e r_state;
    logic [31:0]  r_pc;
    logic [31:0]  r_addr;
    logic         r_req;
    ifid_t        r_ifid;

    logic         w_hold;
    logic         w_ack;
    logic         w_busy;
    logic [31:0]  w_pc4;
    logic [31:0]  w_tgt;
    ifid_t        w_fetched;
    ifid_t        w_buf_q;
    logic         w_buf_full;
    logic         w_buf_ld;
    logic         w_buf_clr;
    logic         w_bub;

    assign w_hold    = PC_stall_i | IFID_stall_i;
    assign w_ack     = imem.imem_ack_i;
    assign w_busy    = (r_state == REQ) || (r_state == DRAIN);
    assign w_pc4     = r_pc + 32'd4;
    assign w_tgt     = target_i & 32'hFFFF_FFFC;
    assign w_fetched = '{pc: w_pc4, instr: imem.imem_data_i, valid: 1'b1};

    assign w_buf_ld  = !flush_i && (r_state == REQ) && w_ack && w_hold;
    assign w_buf_clr = flush_i || ((r_state == HELD) && !w_hold);
    assign w_bub     = flush_i
                     | (!w_hold & (((r_state == REQ) & !w_ack)
                                   | (r_state == DRAIN)));

    fetch_hold_buf u_hold_buf (
        .clk_i   (clk_i),
        .rst_n_i (rst_n_i),
        .i_load  (w_buf_ld),
        .i_clr   (w_buf_clr),
        .i_data  (w_fetched),
        .o_data  (w_buf_q),
        .o_full  (w_buf_full)
    );

    // Flush beats every stall; an unacked request is drained at its old address.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_state <= IDLE;
            r_pc    <= RESET_PC;
            r_addr  <= RESET_PC;
            r_req   <= 1'b0;
            r_ifid  <= IFID_BUBBLE;
        end else if (flush_i) begin
            r_ifid <= IFID_BUBBLE;
            r_pc   <= w_tgt;
            r_req  <= 1'b1;
            if (w_busy && !w_ack) begin
                r_state <= DRAIN;
            end else begin
                r_state <= REQ;
                r_addr  <= w_tgt;
            end
        end else begin
            unique case (r_state)
                IDLE: begin
                    r_state <= REQ;
                    r_req   <= 1'b1;
                    r_addr  <= r_pc;
                end
                REQ: begin
                    if (w_ack && w_hold) begin
                        r_state <= HELD;
                        r_req   <= 1'b0;
                    end else if (w_ack) begin
                        r_ifid <= w_fetched;
                        r_pc   <= w_pc4;
                        r_addr <= w_pc4;
                    end else if (!w_hold) begin
                        r_ifid <= IFID_BUBBLE;
                    end
                end
                HELD: begin
                    if (!w_hold && w_buf_full) begin
                        r_ifid  <= w_buf_q;
                        r_pc    <= w_pc4;
                        r_addr  <= w_pc4;
                        r_req   <= 1'b1;
                        r_state <= REQ;
                    end
                end
                DRAIN: begin
                    if (!w_hold) begin
                        r_ifid <= IFID_BUBBLE;
                    end
                    if (w_ack) begin
                        r_state <= REQ;
                        r_addr  <= r_pc;
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign imem.imem_req_o  = r_req;
    assign imem.imem_addr_o = r_addr;
    assign IFID_pc_o        = r_ifid.pc;
    assign IFID_instr_o     = r_ifid.instr;
    assign IFID_valid_o     = r_ifid.valid;

`ifdef FETCH_PERF_CNT_EN
    logic [31:0] r_stall_cnt;
    logic [31:0] r_bubble_cnt;
    logic [31:0] r_flush_cnt;

    // Counters stick at all-ones instead of wrapping.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_stall_cnt  <= 32'h0;
            r_bubble_cnt <= 32'h0;
            r_flush_cnt  <= 32'h0;
        end else begin
            if (w_hold && (r_stall_cnt != 32'hFFFF_FFFF)) begin
                r_stall_cnt <= r_stall_cnt + 32'd1;
            end
            if (w_bub && (r_bubble_cnt != 32'hFFFF_FFFF)) begin
                r_bubble_cnt <= r_bubble_cnt + 32'd1;
            end
            if (flush_i && (r_flush_cnt != 32'hFFFF_FFFF)) begin
                r_flush_cnt <= r_flush_cnt + 32'd1;
            end
        end
    end

    assign perf_stall_cnt_o  = r_stall_cnt;
    assign perf_bubble_cnt_o = r_bubble_cnt;
    assign perf_flush_cnt_o  = r_flush_cnt;
`else
    logic w_unused_bub;
    assign w_unused_bub = w_bub;
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Scoreboard bench for fetch_stage with a latency-configurable
// instruction memory model.
module tb_fetch_stage;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        PC_stall_i;
    logic        IFID_stall_i;
    logic        flush_i;
    logic [31:0] target_i;
    logic [31:0] IFID_pc_o;
    logic [31:0] IFID_instr_o;
    logic        IFID_valid_o;

    fetch_if u_if ();

    fetch_stage #(.RESET_PC(32'h100)) dut (
        .clk_i        (clk),
        .rst_n_i      (rst_n),
        .PC_stall_i   (PC_stall_i),
        .IFID_stall_i (IFID_stall_i),
        .flush_i      (flush_i),
        .target_i     (target_i),
        .imem         (u_if),
        .IFID_pc_o    (IFID_pc_o),
        .IFID_instr_o (IFID_instr_o),
        .IFID_valid_o (IFID_valid_o)
    );

    always #5 clk = ~clk;

    int   checks = 0;
    int   errors = 0;
    int   lat    = 0;
    int   cnt    = 0;
    exp_t q[$];
    logic        last_v  = 1'b0;
    logic [31:0] last_pc = 32'h0;

    function automatic logic [31:0] mdata(input logic [31:0] a);
        return a ^ 32'h5A5A_0F0F;
    endfunction

    task automatic chk(input string n, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h required %h", n, act, exp);
        end
    endtask

    // Memory: ack after `lat` wait cycles, back-to-back when lat==0.
    initial begin
        u_if.imem_ack_i  = 1'b0;
        u_if.imem_data_i = 32'h0;
    end

    always @(negedge clk) begin
        if (!rst_n || !u_if.imem_req_o) begin
            u_if.imem_ack_i = 1'b0;
            cnt = 0;
        end else if (u_if.imem_ack_i) begin
            if (lat != 0) begin
                u_if.imem_ack_i = 1'b0;
                cnt = 1;
            end
        end else if (cnt >= lat) begin
            u_if.imem_ack_i = 1'b1;
        end else begin
            cnt++;
        end
        u_if.imem_data_i = mdata(u_if.imem_addr_o);
    end

    // Monitor: every newly loaded valid IF/ID entry pops the scoreboard.
    always @(negedge clk) begin
        exp_t e;
        if (!rst_n) begin
            last_v = 1'b0;
        end else begin
            if (IFID_valid_o && !(last_v && IFID_pc_o == last_pc)) begin
                if (q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_ifid got pc=%h instr=%h required none",
                             IFID_pc_o, IFID_instr_o);
                end else begin
                    e = q.pop_front();
                    chk("ifid_pc", IFID_pc_o, e.pc);
                    chk("ifid_instr", IFID_instr_o, e.instr);
                end
            end
            last_v  = IFID_valid_o;
            last_pc = IFID_pc_o;
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [31:0] pc, input logic [31:0] instr);
        exp_t e;
        e.pc    = pc;
        e.instr = instr;
        q.push_back(e);
    endtask

    task automatic reset_dut();
        @(negedge clk);
        #1;
        chk("queue_empty", 32'(q.size()), 32'h0);
        rst_n        = 1'b0;
        PC_stall_i   = 1'b0;
        IFID_stall_i = 1'b0;
        flush_i      = 1'b0;
        target_i     = 32'h0;
        #1;
        chk("rst_req", {31'h0, u_if.imem_req_o}, 32'h0);
        chk("rst_addr", u_if.imem_addr_o, 32'h100);
        chk("rst_valid", {31'h0, IFID_valid_o}, 32'h0);
        chk("rst_pc", IFID_pc_o, 32'h0);
        chk("rst_instr", IFID_instr_o, 32'h0);
        cyc(2);
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n        = 1'b0;
        PC_stall_i   = 1'b0;
        IFID_stall_i = 1'b0;
        flush_i      = 1'b0;
        target_i     = 32'h0;

        // Zero-wait streaming
        lat = 0;
        reset_dut();
        cyc(1);
        chk("p1_addr0", u_if.imem_addr_o, 32'h100);
        chk("p1_req", {31'h0, u_if.imem_req_o}, 32'h1);
        chk("p1_idle_valid", {31'h0, IFID_valid_o}, 32'h0);
        push(32'h104, mdata(32'h100));
        push(32'h108, mdata(32'h104));
        cyc(1);
        chk("p1_addr1", u_if.imem_addr_o, 32'h104);
        cyc(1);
        chk("p1_addr2", u_if.imem_addr_o, 32'h108);

        // Two-wait memory
        lat = 2;
        reset_dut();
        push(32'h104, mdata(32'h100));
        push(32'h108, mdata(32'h104));
        cyc(1);
        chk("p2_addr0", u_if.imem_addr_o, 32'h100);
        repeat (2) begin
            cyc(1);
            chk("p2_bub_valid", {31'h0, IFID_valid_o}, 32'h0);
            chk("p2_bub_instr", IFID_instr_o, 32'h0);
            chk("p2_addr_stable", u_if.imem_addr_o, 32'h100);
        end
        cyc(1);
        chk("p2_addr1", u_if.imem_addr_o, 32'h104);
        cyc(1);
        chk("p2_bub2_valid", {31'h0, IFID_valid_o}, 32'h0);
        chk("p2_addr1_stable", u_if.imem_addr_o, 32'h104);
        cyc(2);
        chk("p2_addr2", u_if.imem_addr_o, 32'h108);

        // Ack arrives during a 3-cycle IF/ID stall
        lat = 0;
        reset_dut();
        flush_i  = 1'b1;
        target_i = 32'h200;
        cyc(1);
        flush_i      = 1'b0;
        IFID_stall_i = 1'b1;
        chk("p3_addr", u_if.imem_addr_o, 32'h200);
        push(32'h204, mdata(32'h200));
        push(32'h208, mdata(32'h204));
        repeat (3) begin
            cyc(1);
            chk("p3_held_valid", {31'h0, IFID_valid_o}, 32'h0);
            chk("p3_held_req", {31'h0, u_if.imem_req_o}, 32'h0);
        end
        IFID_stall_i = 1'b0;
        cyc(1);
        chk("p3_rel_valid", {31'h0, IFID_valid_o}, 32'h1);
        chk("p3_rel_addr", u_if.imem_addr_o, 32'h204);
        chk("p3_rel_req", {31'h0, u_if.imem_req_o}, 32'h1);
        cyc(1);

        // Flush while 0x300 is outstanding
        lat = 2;
        reset_dut();
        flush_i  = 1'b1;
        target_i = 32'h300;
        cyc(1);
        chk("p4_addr300", u_if.imem_addr_o, 32'h300);
        target_i = 32'h403;
        cyc(1);
        flush_i = 1'b0;
        chk("p4_drain_addr", u_if.imem_addr_o, 32'h300);
        chk("p4_drain_req", {31'h0, u_if.imem_req_o}, 32'h1);
        chk("p4_drain_valid", {31'h0, IFID_valid_o}, 32'h0);
        cyc(1);
        chk("p4_drain_addr2", u_if.imem_addr_o, 32'h300);
        cyc(1);
        chk("p4_target_addr", u_if.imem_addr_o, 32'h400);
        chk("p4_discard_valid", {31'h0, IFID_valid_o}, 32'h0);
        push(32'h404, mdata(32'h400));
        cyc(3);

        // Flush with stall, then wrap at the top of memory
        lat = 0;
        reset_dut();
        push(32'h104, mdata(32'h100));
        push(32'h108, mdata(32'h104));
        cyc(3);
        flush_i      = 1'b1;
        IFID_stall_i = 1'b1;
        target_i     = 32'hFFFF_FFFC;
        cyc(1);
        flush_i      = 1'b0;
        IFID_stall_i = 1'b0;
        chk("p5_flush_valid", {31'h0, IFID_valid_o}, 32'h0);
        chk("p5_flush_instr", IFID_instr_o, 32'h0);
        chk("p5_flush_pc", IFID_pc_o, 32'h0);
        chk("p5_flush_addr", u_if.imem_addr_o, 32'hFFFF_FFFC);
        push(32'h0, mdata(32'hFFFF_FFFC));
        push(32'h4, mdata(32'h0));
        cyc(1);
        chk("p5_wrap_addr", u_if.imem_addr_o, 32'h0);
        cyc(1);

        // PC stall behaves like IF/ID stall
        lat = 0;
        reset_dut();
        push(32'h104, mdata(32'h100));
        push(32'h108, mdata(32'h104));
        cyc(2);
        PC_stall_i = 1'b1;
        cyc(1);
        chk("p6_pcst_req", {31'h0, u_if.imem_req_o}, 32'h0);
        chk("p6_pcst_pc", IFID_pc_o, 32'h104);
        PC_stall_i = 1'b0;
        cyc(1);
        chk("p6_rel_addr", u_if.imem_addr_o, 32'h108);
        chk("p6_rel_req", {31'h0, u_if.imem_req_o}, 32'h1);

        // Reset asserted mid-wait
        lat = 2;
        reset_dut();
        cyc(2);
        chk("p7_wait_addr", u_if.imem_addr_o, 32'h100);
        chk("p7_wait_req", {31'h0, u_if.imem_req_o}, 32'h1);
        reset_dut();

        @(negedge clk);
        chk("final_queue_empty", 32'(q.size()), 32'h0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
